// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Button debounce and Start/Pause/Lap/Done control for the 4-digit
//            BCD stopwatch. Define STOPWATCH_LAP_EN to build the lap feature.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
    parameter int TICK_DIV  = 10_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic       count_max,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic       lap_hold,
    output logic [2:0] state
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_LAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Bit order: [0]=start, [1]=lap, [2]=clr
`ifdef STOPWATCH_LAP_EN
    localparam logic [2:0] BTN_EN = 3'b111;
`else
    localparam logic [2:0] BTN_EN = 3'b101;
`endif

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_clr, btn_lap, btn_start};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            if (BTN_EN[i]) begin : g_on
                logic            sync1;
                logic            sync2;
                logic            level;
                logic            level_d;
                logic [DB_W-1:0] db_cnt;

                // Level is accepted only after DB_CYCLES consecutive mismatches.
                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        sync1   <= 1'b0;
                        sync2   <= 1'b0;
                        level   <= 1'b0;
                        level_d <= 1'b0;
                        db_cnt  <= '0;
                    end else begin
                        sync1   <= btn_raw[i];
                        sync2   <= sync1;
                        level_d <= level;
                        if (sync2 == level) begin
                            db_cnt <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            level  <= sync2;
                            db_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end

                assign press[i] = level & ~level_d;
            end else begin : g_off
                logic unused_raw;
                assign unused_raw = btn_raw[i];
                assign press[i]   = 1'b0;
            end
        end
    endgenerate

    logic             do_clr;
    logic             do_start;
    logic             do_lap;
    logic             counting;
    logic             wrap;
    logic             auto_stop;
    logic [2:0]       next_state;
    logic             next_clear;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    assign do_clr    = press[2];
    assign do_start  = press[0] & ~press[2];
    assign do_lap    = press[1] & ~press[0] & ~press[2];
    assign counting  = (state == S_RUN) || (state == S_LAP);
    assign wrap      = counting && (div == DIV_LAST);
    assign auto_stop = wrap && count_max;

    // Auto-stop outranks any press landing in the same cycle.
    always_comb begin
        next_state = state;
        next_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if (do_clr) begin
                    next_clear = 1'b1;
                end else if (do_start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (auto_stop)     next_state = S_DONE;
                else if (do_start) next_state = S_PAUSE;
                else if (do_lap)   next_state = S_LAP;
            end
            S_PAUSE: begin
                if (do_clr) begin
                    next_state = S_IDLE;
                    next_clear = 1'b1;
                end else if (do_start) begin
                    next_state = S_RUN;
                end
            end
            S_LAP: begin
                if (auto_stop)     next_state = S_DONE;
                else if (do_start) next_state = S_PAUSE;
                else if (do_lap)   next_state = S_RUN;
            end
            S_DONE: begin
                if (do_clr) begin
                    next_state = S_IDLE;
                    next_clear = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        div_next = '0;
        if (counting) begin
            div_next = wrap ? '0 : div + 1'b1;
        end else if (state == S_PAUSE) begin
            div_next = div;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            div     <= '0;
            tick    <= 1'b0;
            clear   <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            div     <= div_next;
            tick    <= wrap & ~count_max;
            clear   <= next_clear;
            running <= (next_state == S_RUN) || (next_state == S_LAP);
        end
    end

`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lap_hold <= 1'b0;
        end else begin
            lap_hold <= (next_state == S_LAP);
        end
    end
`else
    assign lap_hold = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed self-checking bench for stopwatch_ctrl (TICK_DIV=10,
//            DB_CYCLES=4). Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int HOLD      = DB_CYCLES + 6;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap   = 1'b0;
    logic       btn_clr   = 1'b0;
    logic       count_max = 1'b0;
    logic       tick;
    logic       clear;
    logic       running;
    logic       lap_hold;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    stopwatch_ctrl #(
        .TICK_DIV (TICK_DIV),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .btn_clr  (btn_clr),
        .count_max(count_max),
        .tick     (tick),
        .clear    (clear),
        .running  (running),
        .lap_hold (lap_hold),
        .state    (state)
    );

    always #5 clk = ~clk;

    // Activity log, sampled shortly after each rising edge.
    int         cyc           = 0;
    int         tick_cnt      = 0;
    int         clear_cnt     = 0;
    int         run_cyc       = 0;
    int         last_run      = 0;
    int         last_tick_cyc = 0;
    int         prev_tick_cyc = 0;
    int         chg_cyc       = 0;
    logic [2:0] prev_state    = 3'd0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (tick === 1'b1) begin
            tick_cnt++;
            last_run      = run_cyc;
            run_cyc       = 0;
            prev_tick_cyc = last_tick_cyc;
            last_tick_cyc = cyc;
        end else if (running === 1'b1) begin
            run_cyc++;
        end
        if (clear === 1'b1) clear_cnt++;
        if (state !== prev_state) chg_cyc = cyc;
        prev_state = state;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic s, input logic l, input logic c);
        @(negedge clk);
        btn_start = s;
        btn_lap   = l;
        btn_clr   = c;
        step(HOLD);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        btn_clr   = 1'b0;
        step(HOLD);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (state === exp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick(input int budget, output bit ok);
        int n0;
        n0 = tick_cnt;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tick_cnt != n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step(3);
        total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
        total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else passed++;
        total++; if (clear !== 1'b0) $display("FAIL reset_clear: got %b want 0", clear); else passed++;
        total++; if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running); else passed++;
        total++; if (lap_hold !== 1'b0) $display("FAIL reset_lap_hold: got %b want 0", lap_hold); else passed++;
        reset_n = 1'b1;
        step(2);
        btn_start = 1'b1; step(1);
        btn_start = 1'b0; step(1);
        btn_start = 1'b1; step(1);
        btn_start = 1'b0;
        step(15);
        total++; if (state !== 3'd0) $display("FAIL bounce_state: got %0d want 0", state); else passed++;
    endtask

    task automatic test_basic_run;
        bit ok;
        int c0;
        int lat;
        @(negedge clk);
        c0 = cyc;
        btn_start = 1'b1;
        wait_state(3'd1, 20, ok);
        btn_start = 1'b0;
        lat = chg_cyc - c0;
        total++; if (state !== 3'd1) $display("FAIL start_state: got %0d want 1", state); else passed++;
        total++; if (lat < 2 + DB_CYCLES || lat > 2 + DB_CYCLES + 3)
            $display("FAIL start_latency: got %0d want %0d..%0d", lat, 2 + DB_CYCLES, 2 + DB_CYCLES + 3);
        else passed++;
        wait_tick(TICK_DIV + 5, ok);
        total++; if (!ok || last_tick_cyc - chg_cyc != TICK_DIV)
            $display("FAIL first_tick: got %0d want %0d (seen %b)", last_tick_cyc - chg_cyc, TICK_DIV, ok);
        else passed++;
        wait_tick(TICK_DIV + 5, ok);
        total++; if (!ok || last_tick_cyc - prev_tick_cyc != TICK_DIV)
            $display("FAIL tick_period: got %0d want %0d (seen %b)", last_tick_cyc - prev_tick_cyc, TICK_DIV, ok);
        else passed++;
    endtask

    task automatic test_pause_resume;
        bit ok;
        int n0;
        step(3);
        push(1'b1, 1'b0, 1'b0);
        total++; if (state !== 3'd2) $display("FAIL pause_state: got %0d want 2", state); else passed++;
        n0 = tick_cnt;
        step(25);
        total++; if (tick_cnt != n0 || running !== 1'b0)
            $display("FAIL pause_no_tick: got %0d ticks running=%b want 0 ticks running=0", tick_cnt - n0, running);
        else passed++;
        @(negedge clk);
        btn_start = 1'b1;
        wait_state(3'd1, 20, ok);
        btn_start = 1'b0;
        total++; if (state !== 3'd1) $display("FAIL resume_state: got %0d want 1", state); else passed++;
        wait_tick(TICK_DIV + 5, ok);
        total++; if (!ok || last_run != TICK_DIV - 1)
            $display("FAIL resume_phase: got %0d run cycles want %0d (seen %b)", last_run + 1, TICK_DIV, ok);
        else passed++;
        step(HOLD);
    endtask

    task automatic test_clear;
        bit ok;
        int k0;
        k0 = clear_cnt;
        push(1'b0, 1'b0, 1'b1);
        total++; if (state !== 3'd1 || clear_cnt != k0)
            $display("FAIL clr_in_run: got state %0d clears %0d want 1 and 0", state, clear_cnt - k0);
        else passed++;
        push(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        btn_clr = 1'b1;
        wait_state(3'd0, 20, ok);
        total++; if (!ok || clear !== 1'b1)
            $display("FAIL clr_in_pause: got state %0d clear %b want 0 and 1", state, clear);
        else passed++;
        @(negedge clk);
        total++; if (clear !== 1'b0) $display("FAIL clear_width: got %b want 0", clear); else passed++;
        btn_clr = 1'b0;
        step(HOLD);
    endtask

    task automatic test_lap;
        int n0;
        push(1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_LAP_EN
        total++; if (state !== 3'd3 || lap_hold !== 1'b1 || running !== 1'b1)
            $display("FAIL lap_enter: got state %0d hold %b run %b want 3 1 1", state, lap_hold, running);
        else passed++;
        n0 = tick_cnt;
        step(25);
        total++; if (tick_cnt - n0 < 2) $display("FAIL lap_ticks: got %0d want >=2", tick_cnt - n0); else passed++;
        push(1'b0, 1'b1, 1'b0);
        total++; if (state !== 3'd1 || lap_hold !== 1'b0)
            $display("FAIL lap_exit: got state %0d hold %b want 1 0", state, lap_hold);
        else passed++;
`else
        n0 = tick_cnt;
        total++; if (state !== 3'd1 || lap_hold !== 1'b0)
            $display("FAIL lap_ignored: got state %0d hold %b want 1 0", state, lap_hold);
        else passed++;
        step(25);
        total++; if (tick_cnt - n0 < 2) $display("FAIL lap_ticks: got %0d want >=2", tick_cnt - n0); else passed++;
`endif
    endtask

    task automatic test_autostop;
        bit ok;
        int n0;
        int k0;
        wait_tick(TICK_DIV + 5, ok);
        count_max = 1'b1;
        n0 = tick_cnt;
        wait_state(3'd4, TICK_DIV + 5, ok);
        total++; if (!ok || tick !== 1'b0 || tick_cnt != n0)
            $display("FAIL autostop: got state %0d tick %b extra %0d want 4 0 0", state, tick, tick_cnt - n0);
        else passed++;
        total++; if (running !== 1'b0) $display("FAIL done_running: got %b want 0", running); else passed++;
        push(1'b1, 1'b0, 1'b0);
        total++; if (state !== 3'd4) $display("FAIL done_start: got %0d want 4", state); else passed++;
        k0 = clear_cnt;
        push(1'b0, 1'b0, 1'b1);
        total++; if (state !== 3'd0 || clear_cnt != k0 + 1)
            $display("FAIL done_clr: got state %0d clears %0d want 0 1", state, clear_cnt - k0);
        else passed++;
        count_max = 1'b0;
    endtask

    task automatic test_priority;
        int k0;
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0);
        k0 = clear_cnt;
        push(1'b1, 1'b0, 1'b1);
        total++; if (state !== 3'd0 || clear_cnt != k0 + 1)
            $display("FAIL prio_clr_start: got state %0d clears %0d want 0 1", state, clear_cnt - k0);
        else passed++;
        push(1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        total++; if (state !== 3'd2 || lap_hold !== 1'b0)
            $display("FAIL prio_start_lap: got state %0d hold %b want 2 0", state, lap_hold);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        int k0;
        push(1'b1, 1'b0, 1'b0);
        k0 = clear_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (state !== 3'd0 || running !== 1'b0 || clear !== 1'b0 || clear_cnt != k0)
            $display("FAIL reset_mid_run: got state %0d run %b clear %b want 0 0 0", state, running, clear);
        else passed++;
        reset_n = 1'b1;
        step(3);
    endtask

    initial begin
        test_reset;
        test_basic_run;
        test_pause_resume;
        test_clear;
        test_lap;
        test_autostop;
        test_priority;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
